// File: rtl/sched_pkg.sv
// Shared definitions for the frame tick scheduler: phase count and order,
// overrun counter width and the sequencer state encoding.
package sched_pkg;

   // Number of per-frame update phases and their fixed execution order.
   localparam int NPHASE  = 3;
   localparam int PH_PHYS = 0;
   localparam int PH_COLL = 1;
   localparam int PH_DRAW = 2;

   // Overrun counter width and its saturation value.
   localparam int                OVR_W   = 8;
   localparam logic [OVR_W-1:0]  OVR_MAX = '1;

   // Sequencer states: idle, or waiting on the owner of phase k.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PHASE0 = 2'd1,
      ST_PHASE1 = 2'd2,
      ST_PHASE2 = 2'd3
   } state_t;

endpackage

// File: rtl/strobe_div.sv
// Wrapping divider 0..DIV-1 with a hold control. 'wrap' is the
// combinational terminal-count condition (used to chain a slower divider
// so its strobe lands in the same cycle); 'tick' is the registered strobe.
module strobe_div #(
   parameter int DIV = 6
) (
   input  logic clk12Mhz,
   input  logic rst_n,
   input  logic en,
   output logic wrap,
   output logic tick
);

   // A divide-by-1 still needs a one-bit counter to stay legal.
   localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign wrap = en && (cnt == LAST);

   // Advance while enabled, wrap at LAST, register the strobe.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk12Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= wrap;
         if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_tick_scheduler.sv
// Clock-enable generator and per-frame phase sequencer on the 12 MHz clock.
// Produces pix_en / frame_tick / anim_tick strobes, runs the physics,
// collision and draw phases in order on every frame tick via req/ack, and
// counts frames skipped because the previous sequence is still running.
// Optional build macro FRAME_WATCHDOG_EN adds a per-phase timeout that
// aborts the sequence and sets the sticky wd_fault flag.
module frame_tick_scheduler
   import sched_pkg::*;
#(
   parameter int PIX_DIV   = 6,
   parameter int FRAME_DIV = 300000,
   parameter int ANIM_DIV  = 4,
   parameter int WD_LIMIT  = 65535
) (
   input  logic              clk12Mhz,
   input  logic              rst_n,
   input  logic              pause,
   output logic              pix_en,
   output logic              frame_tick,
   output logic              anim_tick,
   output logic [NPHASE-1:0] phase_req,
   input  logic [NPHASE-1:0] phase_ack,
   output logic              busy,
   output logic [OVR_W-1:0]  overrun_cnt,
   output logic              wd_fault
);

   logic   pix_wrap;
   logic   frame_wrap;
   logic   anim_wrap;
   state_t state;
   state_t state_next;

   // Pixel enable keeps running while paused so the display stays alive.
   strobe_div #(.DIV(PIX_DIV)) u_pix (
      .clk12Mhz (clk12Mhz),
      .rst_n    (rst_n),
      .en       (1'b1),
      .wrap     (pix_wrap),
      .tick     (pix_en)
   );

   // Frame counter holds its value while paused and resumes from it.
   strobe_div #(.DIV(FRAME_DIV)) u_frame (
      .clk12Mhz (clk12Mhz),
      .rst_n    (rst_n),
      .en       (!pause),
      .wrap     (frame_wrap),
      .tick     (frame_tick)
   );

   // Anim counter advances on the frame wrap condition, so its strobe is
   // registered on the same edge as the matching frame_tick.
   strobe_div #(.DIV(ANIM_DIV)) u_anim (
      .clk12Mhz (clk12Mhz),
      .rst_n    (rst_n),
      .en       (frame_wrap),
      .wrap     (anim_wrap),
      .tick     (anim_tick)
   );

   logic unused_wraps;
   assign unused_wraps = &{1'b0, pix_wrap, anim_wrap};

`ifdef FRAME_WATCHDOG_EN
   localparam int              WD_W    = $clog2(WD_LIMIT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_expire;
`else
   localparam int unused_wd_limit = WD_LIMIT;
`endif

   // Sequencer state register.
   always_ff @(posedge clk12Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and outputs: one-hot request for the active phase, advance
   // on that phase's ack only; acks of other phases are ignored.
   // NOTE: every signal gets a default before the case so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      phase_req  = '0;
      busy       = 1'b1;
`ifdef FRAME_WATCHDOG_EN
      wd_expire  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (frame_tick) state_next = ST_PHASE0;
         end
         ST_PHASE0: begin
            phase_req[PH_PHYS] = 1'b1;
            if (phase_ack[PH_PHYS]) state_next = ST_PHASE1;
         end
         ST_PHASE1: begin
            phase_req[PH_COLL] = 1'b1;
            if (phase_ack[PH_COLL]) state_next = ST_PHASE2;
         end
         ST_PHASE2: begin
            phase_req[PH_DRAW] = 1'b1;
            if (phase_ack[PH_DRAW]) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
`ifdef FRAME_WATCHDOG_EN
      // A phase that reaches the limit without an ack aborts the frame.
      if (busy && ((phase_req & phase_ack) == '0) && (wd_cnt == WD_LAST)) begin
         wd_expire  = 1'b1;
         state_next = ST_IDLE;
      end
`endif
   end

   // Frames that arrive while a sequence is running are skipped and counted.
   always_ff @(posedge clk12Mhz or negedge rst_n) begin
      if (!rst_n) begin
         overrun_cnt <= '0;
      end else if (frame_tick && busy && (overrun_cnt != OVR_MAX)) begin
         overrun_cnt <= overrun_cnt + 1'b1;
      end
   end

`ifdef FRAME_WATCHDOG_EN
   // Per-phase cycle counter, cleared on entry to every phase and in idle.
   always_ff @(posedge clk12Mhz or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if ((state_next != state) || (state == ST_IDLE)) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk12Mhz or negedge rst_n) begin
      if (!rst_n) begin
         wd_fault <= 1'b0;
      end else if (wd_expire) begin
         wd_fault <= 1'b1;
      end
   end
`else
   assign wd_fault = 1'b0;
`endif

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Directed self-checking bench for frame_tick_scheduler.
// Cycle n means the clock-low half after the n-th rising edge following
// reset release; all outputs are sampled there.
module tb_frame_tick_scheduler;

   localparam int PIX_DIV   = 6;
   localparam int FRAME_DIV = 60;
   localparam int ANIM_DIV  = 4;
   localparam int WD_LIMIT  = 20;

   logic       clk12Mhz = 1'b0;
   logic       rst_n    = 1'b0;
   logic       pause    = 1'b0;
   logic       pix_en;
   logic       frame_tick;
   logic       anim_tick;
   logic [2:0] phase_req;
   logic [2:0] phase_ack = 3'b000;
   logic       busy;
   logic [7:0] overrun_cnt;
   logic       wd_fault;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc;

   // Owner model controls
   logic [2:0] ack_en    = 3'b111;
   logic [2:0] force_ack = 3'b000;
   int         ack_delay = 3;
   int         req_age [3] = '{0, 0, 0};

   frame_tick_scheduler #(
      .PIX_DIV   (PIX_DIV),
      .FRAME_DIV (FRAME_DIV),
      .ANIM_DIV  (ANIM_DIV),
      .WD_LIMIT  (WD_LIMIT)
   ) dut (
      .clk12Mhz    (clk12Mhz),
      .rst_n       (rst_n),
      .pause       (pause),
      .pix_en      (pix_en),
      .frame_tick  (frame_tick),
      .anim_tick   (anim_tick),
      .phase_req   (phase_req),
      .phase_ack   (phase_ack),
      .busy        (busy),
      .overrun_cnt (overrun_cnt),
      .wd_fault    (wd_fault)
   );

   always #5 clk12Mhz = ~clk12Mhz;

   // Cycle index since reset release.
   always @(posedge clk12Mhz or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Phase owners: ack becomes visible in the ack_delay-th cycle of a request.
   always @(negedge clk12Mhz) begin
      logic [2:0] ack_v;
      ack_v = force_ack;
      for (int k = 0; k < 3; k++) begin
         if (phase_req[k]) begin
            req_age[k] = req_age[k] + 1;
            if (ack_en[k] && (req_age[k] >= ack_delay)) ack_v[k] = 1'b1;
         end else begin
            req_age[k] = 0;
         end
      end
      phase_ack = ack_v;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk12Mhz);
   endtask

   task automatic do_reset();
      @(negedge clk12Mhz);
      rst_n     = 1'b0;
      pause     = 1'b0;
      ack_en    = 3'b111;
      ack_delay = 3;
      force_ack = 3'b000;
      repeat (2) @(negedge clk12Mhz);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk12Mhz);
      n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL reset pix_en: got %b exp 0", pix_en); end
      n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset frame_tick: got %b exp 0", frame_tick); end
      n_checks++; if (anim_tick !== 1'b0) begin n_fail++; $display("FAIL reset anim_tick: got %b exp 0", anim_tick); end
      n_checks++; if (phase_req !== 3'b000) begin n_fail++; $display("FAIL reset phase_req: got %b exp 000", phase_req); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", busy); end
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset overrun_cnt: got %0d exp 0", overrun_cnt); end
      n_checks++; if (wd_fault !== 1'b0) begin n_fail++; $display("FAIL reset wd_fault: got %b exp 0", wd_fault); end
   endtask

   task automatic test_strobes();
      logic ep, ef, ea;
      do_reset();
      for (int c = 1; c <= 500; c++) begin
         goto(c);
         ep = (c % 6 == 0);
         ef = (c % 60 == 0);
         ea = (c % 240 == 0);
         n_checks++; if (pix_en !== ep) begin n_fail++; $display("FAIL strobe pix_en @%0d: got %b exp %b", c, pix_en, ep); end
         n_checks++; if (frame_tick !== ef) begin n_fail++; $display("FAIL strobe frame_tick @%0d: got %b exp %b", c, frame_tick, ef); end
         n_checks++; if (anim_tick !== ea) begin n_fail++; $display("FAIL strobe anim_tick @%0d: got %b exp %b", c, anim_tick, ea); end
      end
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL strobe overrun_cnt: got %0d exp 0", overrun_cnt); end
   endtask

   task automatic test_sequence();
      logic [2:0] er;
      logic       eb;
      do_reset();
      goto(60);
      n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL seq frame_tick @60: got %b exp 1", frame_tick); end
      n_checks++; if (phase_req !== 3'b000) begin n_fail++; $display("FAIL seq phase_req @60: got %b exp 000", phase_req); end
      for (int c = 61; c <= 71; c++) begin
         goto(c);
         er = (c <= 63) ? 3'b001 : (c <= 66) ? 3'b010 : (c <= 69) ? 3'b100 : 3'b000;
         eb = (c <= 69);
         n_checks++; if (phase_req !== er) begin n_fail++; $display("FAIL seq phase_req @%0d: got %b exp %b", c, phase_req, er); end
         n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL seq busy @%0d: got %b exp %b", c, busy, eb); end
      end
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL seq overrun_cnt: got %0d exp 0", overrun_cnt); end
   endtask

   // Draw ack stuck high: ignored in phases 0/1, completes phase 2 in one cycle.
   task automatic test_ack_edge();
      logic [2:0] er;
      logic       eb;
      do_reset();
      force_ack = 3'b100;
      for (int c = 61; c <= 69; c++) begin
         goto(c);
         er = (c <= 63) ? 3'b001 : (c <= 66) ? 3'b010 : (c == 67) ? 3'b100 : 3'b000;
         eb = (c <= 67);
         n_checks++; if (phase_req !== er) begin n_fail++; $display("FAIL ackedge phase_req @%0d: got %b exp %b", c, phase_req, er); end
         n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL ackedge busy @%0d: got %b exp %b", c, busy, eb); end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      ack_en = 3'b101;
      goto(120);
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL ovr cnt @120: got %0d exp 0", overrun_cnt); end
      n_checks++; if (phase_req !== 3'b010) begin n_fail++; $display("FAIL ovr phase_req @120: got %b exp 010", phase_req); end
      goto(121);
      n_checks++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr cnt @121: got %0d exp 1", overrun_cnt); end
      goto(194);
      n_checks++; if (overrun_cnt !== 8'd2) begin n_fail++; $display("FAIL ovr cnt @194: got %0d exp 2", overrun_cnt); end
      n_checks++; if (phase_req !== 3'b010) begin n_fail++; $display("FAIL ovr phase_req @194: got %b exp 010", phase_req); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr busy @194: got %b exp 1", busy); end
      goto(15301);
      n_checks++; if (overrun_cnt !== 8'd254) begin n_fail++; $display("FAIL ovr cnt @15301: got %0d exp 254", overrun_cnt); end
      goto(15361);
      n_checks++; if (overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL ovr cnt @15361: got %0d exp 255", overrun_cnt); end
      goto(18061);
      n_checks++; if (overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL ovr sat @18061: got %0d exp 255", overrun_cnt); end
      n_checks++; if (phase_req !== 3'b010) begin n_fail++; $display("FAIL ovr phase_req @18061: got %b exp 010", phase_req); end
      ack_en = 3'b111;
      goto(18080);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr release busy: got %b exp 0", busy); end
      n_checks++; if (overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL ovr release cnt: got %0d exp 255", overrun_cnt); end
   endtask

   // Pause at frame count 30 for 100 cycles while phase 1 is in flight.
   task automatic test_pause();
      logic ef, ep;
      do_reset();
      ack_delay = 15;
      goto(90);
      n_checks++; if (phase_req !== 3'b010) begin n_fail++; $display("FAIL pause phase_req @90: got %b exp 010", phase_req); end
      pause = 1'b1;
      for (int c = 91; c <= 220; c++) begin
         goto(c);
         ef = (c == 220);
         ep = (c % 6 == 0);
         n_checks++; if (frame_tick !== ef) begin n_fail++; $display("FAIL pause frame_tick @%0d: got %b exp %b", c, frame_tick, ef); end
         n_checks++; if (pix_en !== ep) begin n_fail++; $display("FAIL pause pix_en @%0d: got %b exp %b", c, pix_en, ep); end
         if (c == 105) begin
            n_checks++; if (phase_req !== 3'b100) begin n_fail++; $display("FAIL pause phase_req @105: got %b exp 100", phase_req); end
         end
         if (c == 106) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pause busy @106: got %b exp 0", busy); end
         end
         if (c == 190) pause = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      ack_delay = 15;
      goto(80);
      n_checks++; if (phase_req !== 3'b010) begin n_fail++; $display("FAIL areset pre phase_req: got %b exp 010", phase_req); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (phase_req !== 3'b000) begin n_fail++; $display("FAIL areset phase_req: got %b exp 000", phase_req); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset busy: got %b exp 0", busy); end
      n_checks++; if (pix_en !== 1'b0 || frame_tick !== 1'b0 || anim_tick !== 1'b0) begin
         n_fail++; $display("FAIL areset strobes: got %b%b%b exp 000", pix_en, frame_tick, anim_tick);
      end
      @(negedge clk12Mhz);
      @(negedge clk12Mhz);
      rst_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         goto(c);
         n_checks++; if (pix_en !== ((c % 6) == 0)) begin n_fail++; $display("FAIL areset pix_en @%0d: got %b exp %b", c, pix_en, (c % 6) == 0); end
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      ack_en = 3'b110;
`ifdef FRAME_WATCHDOG_EN
      goto(80);
      n_checks++; if (phase_req !== 3'b001) begin n_fail++; $display("FAIL wd phase_req @80: got %b exp 001", phase_req); end
      n_checks++; if (wd_fault !== 1'b0) begin n_fail++; $display("FAIL wd fault @80: got %b exp 0", wd_fault); end
      goto(81);
      n_checks++; if (phase_req !== 3'b000) begin n_fail++; $display("FAIL wd phase_req @81: got %b exp 000", phase_req); end
      n_checks++; if (wd_fault !== 1'b1) begin n_fail++; $display("FAIL wd fault @81: got %b exp 1", wd_fault); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd busy @81: got %b exp 0", busy); end
      goto(121);
      n_checks++; if (phase_req !== 3'b001) begin n_fail++; $display("FAIL wd restart phase_req @121: got %b exp 001", phase_req); end
      n_checks++; if (wd_fault !== 1'b1) begin n_fail++; $display("FAIL wd sticky @121: got %b exp 1", wd_fault); end
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL wd overrun @121: got %0d exp 0", overrun_cnt); end
`else
      goto(81);
      n_checks++; if (phase_req !== 3'b001) begin n_fail++; $display("FAIL nowd phase_req @81: got %b exp 001", phase_req); end
      goto(200);
      n_checks++; if (phase_req !== 3'b001) begin n_fail++; $display("FAIL nowd phase_req @200: got %b exp 001", phase_req); end
      n_checks++; if (wd_fault !== 1'b0) begin n_fail++; $display("FAIL nowd wd_fault: got %b exp 0", wd_fault); end
      n_checks++; if (overrun_cnt !== 8'd2) begin n_fail++; $display("FAIL nowd overrun @200: got %0d exp 2", overrun_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_strobes();
      test_sequence();
      test_ack_edge();
      test_overrun();
      test_pause();
      test_async_reset();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
